vending_ctrl: RTL

Parametrised coin-operated vending controller. It accumulates credit from coded coin inputs and issues a one-cycle purchase pulse when credit reaches PRICE. It returns change, or a full refund on cancel, one CHANGE_UNIT per valid/ack handshake with the coin dispenser. It sits between the coin acceptor front-end and the product/change dispensers.

---
 rtl/vending_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/vending_ctrl.sv
// Coin-operated vending controller: accumulates coin credit, pulses purchase at PRICE,
// and pays back change or a cancel refund one CHANGE_UNIT per dispenser handshake.
module vending_ctrl #(
   parameter int CREDIT_W    = 8,
   parameter int PRICE       = 15,
   parameter int VAL1        = 5,
   parameter int VAL2        = 10,
   parameter int VAL3        = 25,
   parameter int CHANGE_UNIT = 5
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [1:0]          cash_in,
   input  logic                cancel,
   input  logic                change_ack,
   output logic                purchase,
   output logic                change_valid,
   output logic                coin_reject,
   output logic [CREDIT_W-1:0] credit,
   output logic [1:0]          state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCUM  = 2'b01,
      ST_VEND   = 2'b10,
      ST_CHANGE = 2'b11
   } state_t;

   // One extra bit so credit+coin overflow is visible before it is committed.
   localparam int SUM_W = CREDIT_W + 1;
   localparam logic [SUM_W-1:0] MAX_CREDIT = {1'b0, {CREDIT_W{1'b1}}};
   localparam logic [SUM_W-1:0] PRICE_S    = SUM_W'(PRICE);
   localparam logic [SUM_W-1:0] UNIT_S     = SUM_W'(CHANGE_UNIT);

   function automatic logic [SUM_W-1:0] coin_value(input logic [1:0] code);
      logic [SUM_W-1:0] v;
      case (code)
         2'b01:   v = SUM_W'(VAL1);
         2'b10:   v = SUM_W'(VAL2);
         2'b11:   v = SUM_W'(VAL3);
         default: v = {SUM_W{1'b0}};
      endcase
      return v;
   endfunction

   state_t               state_q, state_d;
   logic [CREDIT_W-1:0]  credit_q, credit_d;
   logic                 purchase_q, purchase_d;
   logic                 change_valid_q, change_valid_d;
   logic                 coin_reject_q, coin_reject_d;

   logic                 coin_present_s;
   logic                 coin_fits_s;
   logic [SUM_W-1:0]     credit_ext_s;
   logic [SUM_W-1:0]     coin_sum_s;
   logic [SUM_W-1:0]     vend_rem_s;
   logic [SUM_W-1:0]     change_rem_s;

   assign coin_present_s = (cash_in != 2'b00);
   assign credit_ext_s   = {1'b0, credit_q};
   assign coin_sum_s     = credit_ext_s + coin_value(cash_in);
   assign coin_fits_s    = (coin_sum_s <= MAX_CREDIT);
   assign vend_rem_s     = credit_ext_s - PRICE_S;
   assign change_rem_s   = credit_ext_s - UNIT_S;

   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      coin_reject_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (coin_present_s && !cancel && coin_fits_s) begin
               credit_d = coin_sum_s[CREDIT_W-1:0];
               if (coin_sum_s >= PRICE_S) begin
                  state_d = ST_VEND;
               end else begin
                  state_d = ST_ACCUM;
               end
            end else begin
               coin_reject_d = coin_present_s;
            end
         end
         ST_ACCUM: begin
            // Cancel takes priority over a coin arriving on the same edge.
            if (cancel) begin
               state_d       = ST_CHANGE;
               coin_reject_d = coin_present_s;
            end else if (coin_present_s && coin_fits_s) begin
               credit_d = coin_sum_s[CREDIT_W-1:0];
               if (coin_sum_s >= PRICE_S) begin
                  state_d = ST_VEND;
               end else begin
                  state_d = ST_ACCUM;
               end
            end else begin
               coin_reject_d = coin_present_s;
            end
         end
         ST_VEND: begin
            coin_reject_d = coin_present_s;
            if (credit_ext_s > PRICE_S) begin
               credit_d = vend_rem_s[CREDIT_W-1:0];
               state_d  = ST_CHANGE;
            end else begin
               credit_d = {CREDIT_W{1'b0}};
               state_d  = ST_IDLE;
            end
         end
         ST_CHANGE: begin
            coin_reject_d = coin_present_s;
            if (change_ack && change_valid_q) begin
               // Clamp at zero so a partial unit can never wrap the credit.
               if (credit_ext_s > UNIT_S) begin
                  credit_d = change_rem_s[CREDIT_W-1:0];
                  state_d  = ST_CHANGE;
               end else begin
                  credit_d = {CREDIT_W{1'b0}};
                  state_d  = ST_IDLE;
               end
            end else begin
               state_d = ST_CHANGE;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            credit_d = {CREDIT_W{1'b0}};
         end
      endcase
   end

   // Flag outputs follow the next state so they line up with the registered state.
   always_comb begin
      purchase_d     = (state_d == ST_VEND);
      change_valid_d = (state_d == ST_CHANGE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         credit_q       <= {CREDIT_W{1'b0}};
         purchase_q     <= 1'b0;
         change_valid_q <= 1'b0;
         coin_reject_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         credit_q       <= credit_d;
         purchase_q     <= purchase_d;
         change_valid_q <= change_valid_d;
         coin_reject_q  <= coin_reject_d;
      end
   end

   assign purchase     = purchase_q;
   assign change_valid = change_valid_q;
   assign coin_reject  = coin_reject_q;
   assign credit       = credit_q;
   assign state        = state_q;

endmodule
